mem_port_arbiter: RTL and testbench

//  Shares one synchronous-read memory port between two requesters: r0 = CPU FSM load/store path, r1 = I/O/display reader.

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one synchronous-read memory port (issue cycle, then data cycle for reads).
// Optional statistics counters are compiled in when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int PRIO0      = 0,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       gnt_cnt0,
    output logic [15:0]       gnt_cnt1,
    output logic [15:0]       conflict_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_t            state_reg, state_next;
    logic              owner_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              last_gnt_reg;
    logic [7:0]        starve_reg;

    logic [1:0]        req_vec, we_vec, gnt_vec, rvalid_vec, cand_vec;
    logic [ADDR_W-1:0] addr_vec [2];
    logic [DATA_W-1:0] wdata_vec [2];
    logic              arb_edge, win_any, tie_to_r1, pick1;

    assign req_vec      = {r1_req, r0_req};
    assign we_vec       = {r1_we, r0_we};
    assign addr_vec[0]  = r0_addr;
    assign addr_vec[1]  = r1_addr;
    assign wdata_vec[0] = r0_wdata;
    assign wdata_vec[1] = r1_wdata;

    // A requester holding gnt this cycle still shows its old request, so it sits out this edge.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign gnt_vec[gi]    = (state_reg == ISSUE) && (owner_reg == 1'(gi));
            assign rvalid_vec[gi] = (state_reg == DATA) && (owner_reg == 1'(gi));
            assign cand_vec[gi]   = req_vec[gi] && !gnt_vec[gi];
        end
    endgenerate

    always_comb begin
        arb_edge   = 1'b0;
        tie_to_r1  = 1'b0;
        state_next = state_reg;
        case (state_reg)
            IDLE:    arb_edge = 1'b1;
            ISSUE:   arb_edge = we_reg;
            DATA:    arb_edge = 1'b1;
            default: arb_edge = 1'b0;
        endcase
        win_any = arb_edge && (cand_vec != 2'b00);
        if (PRIO0 == 0) begin
            tie_to_r1 = !last_gnt_reg;
        end else begin
            tie_to_r1 = (starve_reg == STARVE_LIM);
        end
        pick1 = cand_vec[1] && (!cand_vec[0] || tie_to_r1);
        case (state_reg)
            IDLE:    state_next = win_any ? ISSUE : IDLE;
            ISSUE:   state_next = !we_reg ? DATA : (win_any ? ISSUE : IDLE);
            DATA:    state_next = win_any ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            owner_reg    <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            last_gnt_reg <= 1'b1;
            starve_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (win_any) begin
                owner_reg    <= pick1;
                we_reg       <= we_vec[pick1];
                addr_reg     <= addr_vec[pick1];
                wdata_reg    <= wdata_vec[pick1];
                last_gnt_reg <= pick1;
                if (PRIO0 != 0) begin
                    if (pick1) begin
                        starve_reg <= '0;
                    end else if (cand_vec[1]) begin
                        starve_reg <= starve_reg + 8'd1;
                    end
                end
            end
        end
    end

    assign r0_gnt    = gnt_vec[0];
    assign r1_gnt    = gnt_vec[1];
    assign r0_rvalid = rvalid_vec[0];
    assign r1_rvalid = rvalid_vec[1];
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_we    = (state_reg == ISSUE) && we_reg;
    assign rdata     = (state_reg == DATA) ? mem_rdata : '0;

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt_cnt0     <= '0;
            gnt_cnt1     <= '0;
            conflict_cnt <= '0;
        end else begin
            if (gnt_vec[0]) begin
                gnt_cnt0 <= gnt_cnt0 + 16'd1;
            end
            if (gnt_vec[1]) begin
                gnt_cnt1 <= gnt_cnt1 + 16'd1;
            end
            if (arb_edge && (cand_vec == 2'b11)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin instance and a fixed-priority instance (STARVE_MAX=2)
// driven by queued requesters and checked each cycle against a transaction-level model.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } txn_t;

    typedef struct {
        int          d;
        int          q;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        int          exp_gnt_lat;
        int          exp_rv_lat;
    } vec_t;

    logic clk;
    logic reset;
    logic mem_init;

    logic [1:0][1:0]       r_req, r_we;
    logic [1:0][1:0][15:0] r_addr, r_wdata;
    logic [1:0][15:0]      mem_rdata;
    wire  [1:0][1:0]       gnt_w, rvalid_w;
    wire  [1:0][15:0]      rdata_w, mem_addr_w, mem_wdata_w;
    wire  [1:0]            mem_we_w;
`ifdef MEM_ARB_STATS_EN
    wire  [1:0][15:0]      gnt_cnt0_w, gnt_cnt1_w, conflict_w;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            mem_port_arbiter #(
                .DATA_W(16), .ADDR_W(16), .PRIO0(gi), .STARVE_MAX(gi == 1 ? 2 : 8)
            ) u_dut (
                .clk(clk), .reset(reset),
                .r0_req(r_req[gi][0]), .r0_we(r_we[gi][0]), .r0_addr(r_addr[gi][0]),
                .r0_wdata(r_wdata[gi][0]), .r0_gnt(gnt_w[gi][0]), .r0_rvalid(rvalid_w[gi][0]),
                .r1_req(r_req[gi][1]), .r1_we(r_we[gi][1]), .r1_addr(r_addr[gi][1]),
                .r1_wdata(r_wdata[gi][1]), .r1_gnt(gnt_w[gi][1]), .r1_rvalid(rvalid_w[gi][1]),
                .rdata(rdata_w[gi]), .mem_addr(mem_addr_w[gi]), .mem_wdata(mem_wdata_w[gi]),
                .mem_we(mem_we_w[gi]), .mem_rdata(mem_rdata[gi])
`ifdef MEM_ARB_STATS_EN
                , .gnt_cnt0(gnt_cnt0_w[gi]), .gnt_cnt1(gnt_cnt1_w[gi]), .conflict_cnt(conflict_w[gi])
`endif
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0010) return 16'hBEEF;
        return {a[7:0], ~a[7:0]};
    endfunction

    // Synchronous-read memory behind each arbiter
    logic [15:0] mem_arr [2][256];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_init) begin
                for (int a = 0; a < 256; a++) mem_arr[d][a] <= init_val(16'(a));
            end else begin
                mem_rdata[d] <= mem_arr[d][mem_addr_w[d][7:0]];
                if (mem_we_w[d]) mem_arr[d][mem_addr_w[d][7:0]] <= mem_wdata_w[d];
            end
        end
    end

    int tests, fails, cyc;

    // Requester queues
    txn_t qbuf [2][2][64];
    int   qh [2][2];
    int   qt [2][2];

    // Reference model state
    logic [15:0] ref_mem [2][256];
    int          m_gnt [2];
    bit          m_read [2];
    int          m_rv [2];
    bit          m_rst [2];
    logic [15:0] m_pend [2];
    logic [15:0] m_rdata_exp [2];
    logic [15:0] m_addr [2];
    logic [15:0] m_wdata [2];
    int          m_last [2];
    int          m_starve [2];
    logic [15:0] m_g0 [2];
    logic [15:0] m_g1 [2];
    logic [15:0] m_conf [2];

    // Observations
    int          gnt_count [2][2];
    int          rv_count [2][2];
    int          last_gnt_cyc [2][2];
    int          last_rv_cyc [2][2];
    logic [15:0] last_rv_data [2][2];
    int          we_count [2];
    int          log_q [2][64];
    int          log_c [2][64];
    int          log_n [2];

    vec_t vecs [9];
    int   fp_exp [6] = '{0, 0, 1, 0, 0, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int q, input logic we, input logic [15:0] a,
                        input logic [15:0] wd);
        if (qt[d][q] - qh[d][q] < 64) begin
            qbuf[d][q][qt[d][q] % 64] = '{we, a, wd};
            qt[d][q]++;
        end
    endtask

    task automatic drive_inputs();
        txn_t t;
        for (int d = 0; d < 2; d++) begin
            for (int q = 0; q < 2; q++) begin
                if (qt[d][q] != qh[d][q]) begin
                    t = qbuf[d][q][qh[d][q] % 64];
                    r_req[d][q]   = 1'b1;
                    r_we[d][q]    = t.we;
                    r_addr[d][q]  = t.addr;
                    r_wdata[d][q] = t.wdata;
                end else begin
                    r_req[d][q] = 1'b0;
                    r_we[d][q]  = 1'b0;
                end
            end
        end
    endtask

    // Decide what the coming clock edge must produce, from the arbitration rules.
    task automatic model_edge(input int d);
        bit c0, c1, port_free;
        int w, n_gnt, n_rv;
        bit n_read;
        if (!reset) begin
            m_gnt[d] = -1; m_read[d] = 0; m_rv[d] = -1; m_rst[d] = 1;
            m_addr[d] = '0; m_wdata[d] = '0; m_last[d] = 1; m_starve[d] = 0;
            m_g0[d] = '0; m_g1[d] = '0; m_conf[d] = '0;
        end else begin
            m_rst[d] = 0;
            if (m_gnt[d] == 0) m_g0[d]++;
            if (m_gnt[d] == 1) m_g1[d]++;
            port_free = !(m_gnt[d] >= 0 && m_read[d]);
            n_rv = port_free ? -1 : m_gnt[d];
            m_rdata_exp[d] = m_pend[d];
            n_gnt = -1; n_read = 0;
            if (port_free) begin
                c0 = r_req[d][0] && (m_gnt[d] != 0);
                c1 = r_req[d][1] && (m_gnt[d] != 1);
                if (c0 && c1) begin
                    m_conf[d]++;
                    if (d == 0) w = 1 - m_last[d];
                    else        w = (m_starve[d] == 2) ? 1 : 0;
                end else if (c0) w = 0;
                else if (c1)     w = 1;
                else             w = -1;
                if (w >= 0) begin
                    n_gnt = w;
                    n_read = !r_we[d][w];
                    m_addr[d] = r_addr[d][w];
                    m_wdata[d] = r_wdata[d][w];
                    m_last[d] = w;
                    if (d == 1) begin
                        if (w == 1) m_starve[d] = 0;
                        else if (c1) m_starve[d]++;
                    end
                    if (r_we[d][w]) ref_mem[d][r_addr[d][w][7:0]] = r_wdata[d][w];
                    else            m_pend[d] = ref_mem[d][r_addr[d][w][7:0]];
                end
            end
            m_gnt[d] = n_gnt; m_read[d] = n_read; m_rv[d] = n_rv;
        end
    endtask

    task automatic observe(input int d);
        logic [4:0] act, exp;
        act = {rvalid_w[d][1], rvalid_w[d][0], gnt_w[d][1], gnt_w[d][0], mem_we_w[d]};
        exp = {m_rv[d] == 1, m_rv[d] == 0, m_gnt[d] == 1, m_gnt[d] == 0,
               (m_gnt[d] >= 0) && !m_read[d]};
        chk($sformatf("d%0d_rv1_rv0_g1_g0_we", d), 32'(act), 32'(exp));
        chk($sformatf("d%0d_mem_addr", d), 32'(mem_addr_w[d]), 32'(m_addr[d]));
        chk($sformatf("d%0d_mem_wdata", d), 32'(mem_wdata_w[d]), 32'(m_wdata[d]));
        if (m_rv[d] >= 0) chk($sformatf("d%0d_rdata", d), 32'(rdata_w[d]), 32'(m_rdata_exp[d]));
        if (m_rst[d]) chk($sformatf("d%0d_rdata_reset", d), 32'(rdata_w[d]), 32'h0);
`ifdef MEM_ARB_STATS_EN
        chk($sformatf("d%0d_gnt_cnt0", d), 32'(gnt_cnt0_w[d]), 32'(m_g0[d]));
        chk($sformatf("d%0d_gnt_cnt1", d), 32'(gnt_cnt1_w[d]), 32'(m_g1[d]));
        chk($sformatf("d%0d_conflict_cnt", d), 32'(conflict_w[d]), 32'(m_conf[d]));
`endif
        for (int q = 0; q < 2; q++) begin
            if (gnt_w[d][q] === 1'b1) begin
                gnt_count[d][q]++;
                last_gnt_cyc[d][q] = cyc;
                if (log_n[d] < 64) begin
                    log_q[d][log_n[d]] = q;
                    log_c[d][log_n[d]] = cyc;
                    log_n[d]++;
                end
                if (qt[d][q] != qh[d][q]) qh[d][q]++;
            end
            if (rvalid_w[d][q] === 1'b1) begin
                rv_count[d][q]++;
                last_rv_cyc[d][q] = cyc;
                last_rv_data[d][q] = rdata_w[d];
            end
        end
        if (mem_we_w[d] === 1'b1) we_count[d]++;
    endtask

    task automatic tick();
        drive_inputs();
        for (int d = 0; d < 2; d++) model_edge(d);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int d = 0; d < 2; d++) observe(d);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int d = 0; d < 2; d++) log_n[d] = 0;
    endtask

    initial begin
        int start, g_before, we_before, rv_before;
        tests = 0; fails = 0; cyc = 0;
        reset = 1'b0; mem_init = 1'b1;
        r_req = '0; r_we = '0; r_addr = '0; r_wdata = '0;
        for (int d = 0; d < 2; d++) begin
            m_gnt[d] = -1; m_read[d] = 0; m_rv[d] = -1; m_rst[d] = 0; m_pend[d] = '0;
            m_rdata_exp[d] = '0; m_addr[d] = '0; m_wdata[d] = '0; m_last[d] = 1; m_starve[d] = 0;
            m_g0[d] = '0; m_g1[d] = '0; m_conf[d] = '0; we_count[d] = 0; log_n[d] = 0;
            for (int a = 0; a < 256; a++) ref_mem[d][a] = init_val(16'(a));
            for (int q = 0; q < 2; q++) begin
                qh[d][q] = 0; qt[d][q] = 0; gnt_count[d][q] = 0; rv_count[d][q] = 0;
                last_gnt_cyc[d][q] = -1; last_rv_cyc[d][q] = -1; last_rv_data[d][q] = '0;
            end
        end
        vecs[0] = '{0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 1, 2};
        vecs[1] = '{0, 1, 1, 16'h0020, 16'hA5A5, 16'h0000, 1, 0};
        vecs[2] = '{0, 1, 1, 16'h0021, 16'h5A5A, 16'h0000, 1, 0};
        vecs[3] = '{0, 0, 0, 16'h0020, 16'h0000, 16'hA5A5, 1, 2};
        vecs[4] = '{0, 1, 0, 16'h0021, 16'h0000, 16'h5A5A, 1, 2};
        vecs[5] = '{1, 1, 0, 16'h0010, 16'h0000, 16'hBEEF, 1, 2};
        vecs[6] = '{1, 0, 1, 16'h0030, 16'h1234, 16'h0000, 1, 0};
        vecs[7] = '{1, 1, 0, 16'h0030, 16'h0000, 16'h1234, 1, 2};
        vecs[8] = '{1, 0, 0, 16'h0031, 16'h0000, 16'h31CE, 1, 2};

        tick();
        tick();
        mem_init = 1'b0;
        reset = 1'b1;
        tick();

        // Single transactions from idle: latency and data
        foreach (vecs[i]) begin
            last_gnt_cyc[vecs[i].d][vecs[i].q] = -1;
            last_rv_cyc[vecs[i].d][vecs[i].q] = -1;
            start = cyc;
            push(vecs[i].d, vecs[i].q, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            for (int k = 0; k < 4; k++) tick();
            chk($sformatf("vec%0d_gnt_latency", i),
                32'(last_gnt_cyc[vecs[i].d][vecs[i].q] - start), 32'(vecs[i].exp_gnt_lat));
            if (vecs[i].exp_rv_lat > 0) begin
                chk($sformatf("vec%0d_rvalid_latency", i),
                    32'(last_rv_cyc[vecs[i].d][vecs[i].q] - start), 32'(vecs[i].exp_rv_lat));
                chk($sformatf("vec%0d_rdata", i),
                    32'(last_rv_data[vecs[i].d][vecs[i].q]), 32'(vecs[i].exp_rdata));
            end else begin
                chk($sformatf("vec%0d_no_rvalid", i),
                    32'(last_rv_cyc[vecs[i].d][vecs[i].q]), 32'hFFFF_FFFF);
            end
        end

        // r1 holds two writes back to back
        g_before = gnt_count[0][1];
        push(0, 1, 1'b1, 16'h0020, 16'hA5A5);
        push(0, 1, 1'b1, 16'h0021, 16'h5A5A);
        for (int k = 0; k < 6; k++) tick();
        chk("two_writes_r1_gnt_pulses", 32'(gnt_count[0][1] - g_before), 32'd2);
        push(0, 0, 1'b0, 16'h0021, 16'h0000);
        for (int k = 0; k < 4; k++) tick();
        chk("two_writes_readback", 32'(last_rv_data[0][0]), 32'h5A5A);

        // Writes from both requesters issue on consecutive cycles
        we_before = we_count[0];
        push(0, 0, 1'b1, 16'h0022, 16'h1111);
        push(0, 1, 1'b1, 16'h0023, 16'h2222);
        for (int k = 0; k < 5; k++) tick();
        chk("mixed_writes_mem_we_cycles", 32'(we_count[0] - we_before), 32'd2);
        chk("mixed_writes_gap",
            32'((last_gnt_cyc[0][0] > last_gnt_cyc[0][1]) ? last_gnt_cyc[0][0] - last_gnt_cyc[0][1]
                                                          : last_gnt_cyc[0][1] - last_gnt_cyc[0][0]),
            32'd1);

        // Both requesters streaming reads: round-robin and starvation guard
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push(0, 0, 1'b0, 16'(8'h40 + k), 16'h0);
            push(0, 1, 1'b0, 16'(8'h50 + k), 16'h0);
        end
        for (int k = 0; k < 6; k++) push(1, 0, 1'b0, 16'(8'h60 + k), 16'h0);
        for (int k = 0; k < 4; k++) push(1, 1, 1'b0, 16'(8'h70 + k), 16'h0);
        for (int k = 0; k < 26; k++) tick();
        chk("rr_grant_total", 32'(log_n[0]), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("rr_order_%0d", i), 32'(log_q[0][i]), 32'(i % 2));
        for (int i = 1; i < 8; i++)
            chk($sformatf("rr_spacing_%0d", i), 32'(log_c[0][i] - log_c[0][i-1]), 32'd2);
        for (int i = 0; i < 6; i++) chk($sformatf("fp_order_%0d", i), 32'(log_q[1][i]), 32'(fp_exp[i]));
`ifdef MEM_ARB_STATS_EN
        chk("stats_rr_gnt_cnt0", 32'(gnt_cnt0_w[0]), 32'd4);
        chk("stats_rr_gnt_cnt1", 32'(gnt_cnt1_w[0]), 32'd4);
        chk("stats_rr_conflict_cnt", 32'(conflict_w[0]), 32'd7);
`endif

        // Reset during the issue cycle of a read, then a pending r1 read
        do_reset();
        rv_before = rv_count[0][0];
        last_gnt_cyc[0][1] = -1;
        last_rv_cyc[0][1] = -1;
        start = cyc;
        push(0, 0, 1'b0, 16'h0010, 16'h0);
        tick();
        chk("rst_mid_read_gnt_seen", 32'(gnt_w[0][0]), 32'd1);
        reset = 1'b0;
        push(0, 1, 1'b0, 16'h0031, 16'h0);
        tick();
        chk("rst_mid_read_outputs_zero",
            32'({gnt_w[0], rvalid_w[0], mem_we_w[0], mem_addr_w[0]}), 32'h0);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("rst_mid_read_r1_gnt_latency", 32'(last_gnt_cyc[0][1] - start), 32'd3);
        chk("rst_mid_read_r1_rvalid_latency", 32'(last_rv_cyc[0][1] - start), 32'd4);
        chk("rst_mid_read_r1_rdata", 32'(last_rv_data[0][1]), 32'h31CE);
        chk("rst_mid_read_no_r0_rvalid", 32'(rv_count[0][0] - rv_before), 32'd0);

        // Random traffic against the model
        for (int t = 0; t < 500; t++) begin
            for (int d = 0; d < 2; d++) begin
                for (int q = 0; q < 2; q++) begin
                    if ($urandom_range(0, 3) == 0 && (qt[d][q] - qh[d][q]) < 6)
                        push(d, q, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)),
                             16'($urandom));
                end
            end
            if (t == 250) reset = 1'b0;
            tick();
            reset = 1'b1;
        end
        for (int k = 0; k < 60; k++) tick();
        for (int d = 0; d < 2; d++)
            for (int q = 0; q < 2; q++)
                chk($sformatf("drain_d%0d_r%0d", d, q), 32'(qt[d][q] - qh[d][q]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
